// File: rtl/line_fill_unit_if.sv
// Signal bundle between the cache miss path, the line fill unit and the main-memory read port.
// The master view belongs to the fill unit; the slave view is the cache and memory environment.
interface line_fill_unit_if #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 64,
   parameter int BLOCKS_PER_LINE = 4
);
   localparam int IDX_W = $clog2(BLOCKS_PER_LINE);

   logic                  fill_req;
   logic [ADDR_WIDTH-1:0] fill_address;
   logic                  fill_ready;
   logic                  mem_req;
   logic [31:0]           mem_address;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  fill_valid;
   logic [DATA_WIDTH-1:0] fill_data;
   logic [IDX_W-1:0]      fill_block;
   logic                  fill_last;
   logic                  fill_done;
   logic                  fill_error;

   modport master (
      input  fill_req, fill_address, mem_ack, mem_data,
      output fill_ready, mem_req, mem_address, fill_valid, fill_data,
             fill_block, fill_last, fill_done, fill_error
   );

   modport slave (
      output fill_req, fill_address, mem_ack, mem_data,
      input  fill_ready, mem_req, mem_address, fill_valid, fill_data,
             fill_block, fill_last, fill_done, fill_error
   );
endinterface

// File: rtl/line_fill_unit.sv
// Cache line refill engine: fetches one line from main memory, critical block first with wrap,
// streaming each block back to the cache and aborting with an error if a beat is not acked in time.
module line_fill_unit #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 64,
   parameter int BLOCKS_PER_LINE = 4,
   parameter int BLOCK_BITS      = 3,
   parameter int CRITICAL_FIRST  = 1,
   parameter int TIMEOUT         = 255
) (
   input  logic             clock,
   input  logic             reset,
   line_fill_unit_if.master bus
);
   localparam int IDX_W    = $clog2(BLOCKS_PER_LINE);
   localparam int LINE_LSB = BLOCK_BITS + IDX_W;
   localparam int LINE_W   = ADDR_WIDTH - LINE_LSB;
   localparam logic [IDX_W-1:0] LAST_BEAT  = IDX_W'(BLOCKS_PER_LINE - 1);
   localparam logic [15:0]      WAIT_LIMIT = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DONE, ERROR} state_t;

   state_t                state_q, state_d;
   logic [LINE_W-1:0]     line_q, line_d;
   logic [IDX_W-1:0]      start_q, start_d;
   logic [IDX_W-1:0]      beat_q, beat_d;
   logic [15:0]           wait_q, wait_d;
   logic                  fill_ready_q, fill_ready_d;
   logic                  mem_req_q, mem_req_d;
   logic [31:0]           mem_address_q, mem_address_d;
   logic                  fill_valid_q, fill_valid_d;
   logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
   logic [IDX_W-1:0]      fill_block_q, fill_block_d;
   logic                  fill_last_q, fill_last_d;
   logic                  fill_done_q, fill_done_d;
   logic                  fill_error_q, fill_error_d;

   logic                  accept;
   logic [IDX_W-1:0]      cur_block;
   logic [IDX_W-1:0]      first_block;
   logic [LINE_W-1:0]     req_line;
   logic                  unused_addr_bits;

   function automatic logic [31:0] word_address(input logic [LINE_W-1:0] line,
                                                input logic [IDX_W-1:0]  block);
      return 32'({line, block});
   endfunction

   assign accept           = (state_q == IDLE) && fill_ready_q && bus.fill_req;
   assign cur_block        = start_q + beat_q;
   assign req_line         = bus.fill_address[ADDR_WIDTH-1:LINE_LSB];
   assign first_block      = (CRITICAL_FIRST != 0) ? bus.fill_address[LINE_LSB-1:BLOCK_BITS] : '0;
   assign unused_addr_bits = ^bus.fill_address[BLOCK_BITS-1:0];

   // Next-state and next-output logic; every output is registered so the cache sees clean edges.
   // Readiness returns one cycle after the done pulse (normal end) or right after the error pulse.
   always_comb begin
      state_d       = state_q;
      line_d        = line_q;
      start_d       = start_q;
      beat_d        = beat_q;
      wait_d        = wait_q;
      fill_ready_d  = fill_ready_q;
      mem_req_d     = mem_req_q;
      mem_address_d = mem_address_q;
      fill_valid_d  = 1'b0;
      fill_data_d   = fill_data_q;
      fill_block_d  = fill_block_q;
      fill_last_d   = 1'b0;
      fill_done_d   = 1'b0;
      fill_error_d  = 1'b0;

      case (state_q)
         IDLE: begin
            fill_ready_d = 1'b1;
            if (accept) begin
               state_d       = FETCH;
               line_d        = req_line;
               start_d       = first_block;
               beat_d        = '0;
               wait_d        = '0;
               fill_ready_d  = 1'b0;
               mem_req_d     = 1'b1;
               mem_address_d = word_address(req_line, first_block);
            end
         end
         FETCH: begin
            // An ack arriving on the cycle the wait limit is reached still counts as a beat.
            if (bus.mem_ack) begin
               fill_valid_d  = 1'b1;
               fill_data_d   = bus.mem_data;
               fill_block_d  = cur_block;
               beat_d        = beat_q + IDX_W'(1);
               wait_d        = '0;
               mem_address_d = word_address(line_q, cur_block + IDX_W'(1));
               if (beat_q == LAST_BEAT) begin
                  fill_last_d = 1'b1;
                  mem_req_d   = 1'b0;
                  state_d     = DONE;
               end
            end else if (wait_q == WAIT_LIMIT) begin
               mem_req_d    = 1'b0;
               fill_done_d  = 1'b1;
               fill_error_d = 1'b1;
               state_d      = ERROR;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         DONE: begin
            fill_done_d = 1'b1;
            state_d     = IDLE;
         end
         ERROR: begin
            fill_ready_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         line_q        <= '0;
         start_q       <= '0;
         beat_q        <= '0;
         wait_q        <= '0;
         fill_ready_q  <= 1'b1;
         mem_req_q     <= 1'b0;
         mem_address_q <= '0;
         fill_valid_q  <= 1'b0;
         fill_data_q   <= '0;
         fill_block_q  <= '0;
         fill_last_q   <= 1'b0;
         fill_done_q   <= 1'b0;
         fill_error_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         line_q        <= line_d;
         start_q       <= start_d;
         beat_q        <= beat_d;
         wait_q        <= wait_d;
         fill_ready_q  <= fill_ready_d;
         mem_req_q     <= mem_req_d;
         mem_address_q <= mem_address_d;
         fill_valid_q  <= fill_valid_d;
         fill_data_q   <= fill_data_d;
         fill_block_q  <= fill_block_d;
         fill_last_q   <= fill_last_d;
         fill_done_q   <= fill_done_d;
         fill_error_q  <= fill_error_d;
      end
   end

   assign bus.fill_ready  = fill_ready_q;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_address = mem_address_q;
   assign bus.fill_valid  = fill_valid_q;
   assign bus.fill_data   = fill_data_q;
   assign bus.fill_block  = fill_block_q;
   assign bus.fill_last   = fill_last_q;
   assign bus.fill_done   = fill_done_q;
   assign bus.fill_error  = fill_error_q;
endmodule

// File: tb/tb_line_fill_unit.sv
// Bench for line_fill_unit: a critical-first and a block-0-first instance share one stimulus stream
// and are both checked every cycle against a schedule-based reference of the fill protocol.
module tb_line_fill_unit;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int BPL = 4;
   localparam int TO = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          fill_req;
   logic [AW-1:0] fill_address;
   logic          mem_ack;
   logic          scramble;

   always #5 clock = ~clock;

   line_fill_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCKS_PER_LINE(BPL)) bus_cf ();
   line_fill_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCKS_PER_LINE(BPL)) bus_lin ();

   line_fill_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCKS_PER_LINE(BPL), .BLOCK_BITS(3),
                    .CRITICAL_FIRST(1), .TIMEOUT(TO))
      dut_cf (.clock(clock), .reset(reset), .bus(bus_cf.master));

   line_fill_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCKS_PER_LINE(BPL), .BLOCK_BITS(3),
                    .CRITICAL_FIRST(0), .TIMEOUT(TO))
      dut_lin (.clock(clock), .reset(reset), .bus(bus_lin.master));

   // Main memory: word i holds i in the low half; the high half is optionally scrambled.
   function automatic logic [63:0] mem_word(input logic [31:0] a, input logic s);
      return {(s ? ~a : 32'h0), a};
   endfunction

   assign bus_cf.fill_req      = fill_req;
   assign bus_cf.fill_address  = fill_address;
   assign bus_cf.mem_ack       = mem_ack;
   assign bus_cf.mem_data      = mem_word(bus_cf.mem_address, scramble);
   assign bus_lin.fill_req     = fill_req;
   assign bus_lin.fill_address = fill_address;
   assign bus_lin.mem_ack      = mem_ack;
   assign bus_lin.mem_data     = mem_word(bus_lin.mem_address, scramble);

   logic        o_ready[2], o_req[2], o_valid[2], o_last[2], o_done[2], o_err[2];
   logic [31:0] o_addr[2];
   logic [63:0] o_data[2];
   logic [1:0]  o_blk[2];

   assign o_ready[0] = bus_cf.fill_ready;  assign o_ready[1] = bus_lin.fill_ready;
   assign o_req[0]   = bus_cf.mem_req;     assign o_req[1]   = bus_lin.mem_req;
   assign o_valid[0] = bus_cf.fill_valid;  assign o_valid[1] = bus_lin.fill_valid;
   assign o_last[0]  = bus_cf.fill_last;   assign o_last[1]  = bus_lin.fill_last;
   assign o_done[0]  = bus_cf.fill_done;   assign o_done[1]  = bus_lin.fill_done;
   assign o_err[0]   = bus_cf.fill_error;  assign o_err[1]   = bus_lin.fill_error;
   assign o_addr[0]  = bus_cf.mem_address; assign o_addr[1]  = bus_lin.mem_address;
   assign o_data[0]  = bus_cf.fill_data;   assign o_data[1]  = bus_lin.fill_data;
   assign o_blk[0]   = bus_cf.fill_block;  assign o_blk[1]   = bus_lin.fill_block;

   int    total = 0;
   int    bad = 0;
   string tag[2] = '{"cf", "lin"};

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: per fill a line/start/beat count/wait count, plus the edges at which the
   // trailing done pulse and the return of readiness are due.
   int          cyc = 0;
   bit          model_live = 1'b0;
   bit          m_active[2];
   int          m_line[2], m_start[2], m_k[2], m_wait[2], m_done_at[2], m_ready_at[2];
   bit          e_ready[2], e_req[2], e_valid[2], e_last[2], e_done[2], e_err[2];
   logic [31:0] e_addr[2];
   logic [63:0] e_data[2];
   int          e_blk[2];

   task automatic model_step(input int d);
      if (reset) begin
         model_live  = 1'b1;
         m_active[d] = 1'b0;
         e_ready[d]  = 1'b1;
         e_req[d]    = 1'b0;
         e_valid[d]  = 1'b0;
         e_last[d]   = 1'b0;
         e_done[d]   = 1'b0;
         e_err[d]    = 1'b0;
         e_addr[d]   = '0;
         e_data[d]   = '0;
         e_blk[d]    = 0;
         m_done_at[d]  = -1;
         m_ready_at[d] = -1;
      end else begin
         e_valid[d] = 1'b0;
         e_last[d]  = 1'b0;
         e_done[d]  = 1'b0;
         e_err[d]   = 1'b0;
         if (e_ready[d] && fill_req) begin
            e_ready[d]  = 1'b0;
            m_active[d] = 1'b1;
            m_line[d]   = int'(fill_address >> 5);
            m_start[d]  = (d == 0) ? int'(fill_address[4:3]) : 0;
            m_k[d]      = 0;
            m_wait[d]   = 0;
            e_req[d]    = 1'b1;
            e_addr[d]   = 32'(m_line[d] * 4 + m_start[d]);
         end else if (m_active[d]) begin
            if (mem_ack) begin
               e_valid[d] = 1'b1;
               e_data[d]  = mem_word(e_addr[d], scramble);
               e_blk[d]   = (m_start[d] + m_k[d]) % 4;
               m_k[d]++;
               m_wait[d]  = 0;
               if (m_k[d] == 4) begin
                  e_last[d]     = 1'b1;
                  e_req[d]      = 1'b0;
                  m_active[d]   = 1'b0;
                  m_done_at[d]  = cyc + 1;
                  m_ready_at[d] = cyc + 2;
               end else begin
                  e_addr[d] = 32'(m_line[d] * 4 + (m_start[d] + m_k[d]) % 4);
               end
            end else begin
               m_wait[d]++;
               if (m_wait[d] == TO) begin
                  e_req[d]      = 1'b0;
                  e_done[d]     = 1'b1;
                  e_err[d]      = 1'b1;
                  m_active[d]   = 1'b0;
                  m_ready_at[d] = cyc + 1;
               end
            end
         end
         if (cyc == m_done_at[d])  e_done[d]  = 1'b1;
         if (cyc == m_ready_at[d]) e_ready[d] = 1'b1;
      end
   endtask

   always @(posedge clock) begin
      model_step(0);
      model_step(1);
      cyc++;
   end

   // Every-cycle comparison; data/block only matter on a beat, the address only while requesting.
   always @(negedge clock) begin
      if (model_live) begin
         for (int d = 0; d < 2; d++) begin
            checkOutput({tag[d], ".fill_ready"}, 64'(o_ready[d]), 64'(e_ready[d]));
            checkOutput({tag[d], ".mem_req"},    64'(o_req[d]),   64'(e_req[d]));
            checkOutput({tag[d], ".fill_valid"}, 64'(o_valid[d]), 64'(e_valid[d]));
            checkOutput({tag[d], ".fill_last"},  64'(o_last[d]),  64'(e_last[d]));
            checkOutput({tag[d], ".fill_done"},  64'(o_done[d]),  64'(e_done[d]));
            checkOutput({tag[d], ".fill_error"}, 64'(o_err[d]),   64'(e_err[d]));
            if (e_req[d])
               checkOutput({tag[d], ".mem_address"}, 64'(o_addr[d]), 64'(e_addr[d]));
            if (e_valid[d]) begin
               checkOutput({tag[d], ".fill_data"},  o_data[d], e_data[d]);
               checkOutput({tag[d], ".fill_block"}, 64'(o_blk[d]), 64'(e_blk[d]));
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic ack);
      fill_req     = req;
      fill_address = addr;
      mem_ack      = ack;
   endtask

   task automatic idle(input int n);
      fill_req = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   int lit_blk[2][4]  = '{'{1, 2, 3, 0}, '{0, 1, 2, 3}};
   int lit_addr[2][4] = '{'{32'h805, 32'h806, 32'h807, 32'h804}, '{32'h804, 32'h805, 32'h806, 32'h807}};

   initial begin
      int pulses, errs, dones, drought;
      scramble = 1'b0;
      reset    = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0);
      repeat (3) step();
      reset = 1'b0;
      checkOutput("reset.fill_ready", 64'(o_ready[0]), 64'd1);
      checkOutput("reset.mem_req", 64'(o_req[0]), 64'd0);
      checkOutput("reset.fill_done", 64'(o_done[0]), 64'd0);

      // Critical-first and block-0-first fills of 0x4028 against a zero-wait memory.
      $display("[TB] directed: zero-wait fill of 0x4028");
      applyStimulus(1'b1, 32'h0000_4028, 1'b1);
      step();
      fill_req = 1'b0;
      for (int d = 0; d < 2; d++)
         checkOutput({tag[d], ".lit.addr0"}, 64'(o_addr[d]), 64'(lit_addr[d][0]));
      for (int i = 0; i < 4; i++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checkOutput({tag[d], ".lit.valid"}, 64'(o_valid[d]), 64'd1);
            checkOutput({tag[d], ".lit.block"}, 64'(o_blk[d]), 64'(lit_blk[d][i]));
            checkOutput({tag[d], ".lit.data"}, o_data[d], 64'(32'h804 + lit_blk[d][i]));
            checkOutput({tag[d], ".lit.last"}, 64'(o_last[d]), 64'(i == 3));
            if (i < 3)
               checkOutput({tag[d], ".lit.addr"}, 64'(o_addr[d]), 64'(lit_addr[d][i + 1]));
         end
      end
      checkOutput("lit.req_dropped", 64'(o_req[0]), 64'd0);
      step();
      checkOutput("lit.done", 64'(o_done[0]), 64'd1);
      checkOutput("lit.not_ready_yet", 64'(o_ready[0]), 64'd0);
      step();
      checkOutput("lit.ready_back", 64'(o_ready[0]), 64'd1);
      checkOutput("lit.done_cleared", 64'(o_done[0]), 64'd0);
      idle(3);

      // Ack only every 4th cycle: four isolated beats and no timeout.
      $display("[TB] directed: slow memory");
      applyStimulus(1'b1, 32'h1234_5678, 1'b0);
      step();
      fill_req = 1'b0;
      pulses = 0; errs = 0; dones = 0;
      for (int c = 0; c < 40; c++) begin
         mem_ack = (c % 4 == 3);
         step();
         pulses += int'(o_valid[0]);
         errs   += int'(o_err[0]);
         dones  += int'(o_done[0]);
      end
      mem_ack = 1'b0;
      checkOutput("slow.beats", 64'(pulses), 64'd4);
      checkOutput("slow.errors", 64'(errs), 64'd0);
      checkOutput("slow.dones", 64'(dones), 64'd1);
      idle(3);

      // No ack at all: error pulse 8 cycles after mem_req rises.
      $display("[TB] directed: timeout");
      applyStimulus(1'b1, 32'h0000_0100, 1'b0);
      step();
      fill_req = 1'b0;
      for (int i = 1; i <= TO; i++) begin
         checkOutput("to.req_held", 64'(o_req[0]), 64'd1);
         checkOutput("to.no_done", 64'(o_done[0]), 64'd0);
         step();
      end
      checkOutput("to.done", 64'(o_done[0]), 64'd1);
      checkOutput("to.error", 64'(o_err[0]), 64'd1);
      checkOutput("to.req_low", 64'(o_req[0]), 64'd0);
      checkOutput("to.no_last", 64'(o_last[0]), 64'd0);
      step();
      checkOutput("to.ready", 64'(o_ready[0]), 64'd1);
      idle(3);

      // Reset one cycle after the second beat, then a clean fill of line 0.
      $display("[TB] directed: reset mid-fill");
      applyStimulus(1'b1, 32'h0000_0A18, 1'b1);
      step();
      fill_req = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("rst.valid", 64'(o_valid[0]), 64'd0);
      checkOutput("rst.req", 64'(o_req[0]), 64'd0);
      checkOutput("rst.addr", 64'(o_addr[0]), 64'd0);
      checkOutput("rst.data", o_data[0], 64'd0);
      checkOutput("rst.ready", 64'(o_ready[0]), 64'd1);
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         dones += int'(o_done[0]);
      end
      checkOutput("rst.no_done", 64'(dones), 64'd0);
      applyStimulus(1'b1, 32'h0, 1'b1);
      step();
      fill_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("rst.refill.block", 64'(o_blk[0]), 64'(i));
         checkOutput("rst.refill.data", o_data[0], 64'(i));
      end
      idle(4);

      // fill_req held high: fills follow each other only when fill_ready is seen.
      $display("[TB] directed: fill_req held high");
      applyStimulus(1'b1, 32'h0000_2040, 1'b1);
      pulses = 0; dones = 0;
      for (int i = 0; i < 21; i++) begin
         step();
         pulses += int'(o_valid[0]);
         dones  += int'(o_done[0]);
      end
      fill_req = 1'b0;
      checkOutput("held.dones", 64'(dones), 64'd3);
      checkOutput("held.beats", 64'(pulses), 64'd12);
      idle(4);

      // Random traffic with ack droughts long enough to time out and rare resets.
      $display("[TB] random traffic");
      scramble = 1'b1;
      drought  = 0;
      for (int i = 0; i < 4000; i++) begin
         fill_req     = ($urandom_range(0, 3) != 0);
         fill_address = $urandom;
         if (drought > 0) begin
            mem_ack = 1'b0;
            drought--;
         end else begin
            mem_ack = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 59) == 0) drought = $urandom_range(3, 12);
         end
         reset = ($urandom_range(0, 399) == 0);
         step();
      end
      reset   = 1'b0;
      mem_ack = 1'b1;
      idle(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
